// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer.
// Holds the packet-state encoding and a width helper used to size the
// internal lane tag.
package stream_demux_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUTE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ROUTE = ST_ROUTE,
        S_DROP  = ST_DROP
    } state_e;

    // Bits needed to hold a lane index 0..n-1 (never less than one bit).
    function automatic int clog2(input int n);
        int w;
        int p;
        w = 32'sd1;
        p = 32'sd2;
        while (p < n) begin
            p = p * 32'sd2;
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_demux_slice.sv
// Single-entry register slice carrying a data word, a last flag and a lane tag.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid/in_ready upstream handshake (ready = empty or draining)
//   in_data/in_last/in_ch  beat contents and destination tag
//   out_ready         ready of the lane the held beat is tagged for
//   full, drain       entry occupied / entry leaving at this edge
//   data, last, ch    registered beat contents
module stream_demux_slice
    import stream_demux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CH_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_last,
    input  logic [CH_WIDTH-1:0] in_ch,
    input  logic                out_ready,
    output logic                full,
    output logic                drain,
    output logic [WIDTH-1:0]    data,
    output logic                last,
    output logic [CH_WIDTH-1:0] ch
);

    logic                full_r;
    logic [WIDTH-1:0]    data_r;
    logic                last_r;
    logic [CH_WIDTH-1:0] ch_r;
    logic                drain_s;
    logic                load_s;

    // Accepting while draining keeps full throughput with no bubble.
    assign drain_s  = full_r && out_ready;
    assign in_ready = !full_r || drain_s;
    assign load_s   = in_valid && in_ready;

    assign full  = full_r;
    assign drain = drain_s;
    assign data  = data_r;
    assign last  = last_r;
    assign ch    = ch_r;

    // Slice storage: load on accepted beat, empty on drain without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 1'b0;
            data_r <= {WIDTH{1'b0}};
            last_r <= 1'b0;
            ch_r   <= {CH_WIDTH{1'b0}};
        end else if (load_s) begin
            full_r <= 1'b1;
            data_r <= in_data;
            last_r <= in_last;
            ch_r   <= in_ch;
        end else if (drain_s) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready/last stream to one of N_OUTPUTS lanes. The lane is
// taken from sel on a packet's first beat and held until its last beat.
// Packets addressed to a non-existent lane are swallowed and counted.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   sel                   destination lane, sampled on first beats only
//   s_tdata/s_tvalid/s_tlast/s_tready   input stream
//   m_tdata               registered word replicated on every lane
//   m_tvalid              one-hot (or zero) lane valid
//   m_tlast               registered last flag replicated on every lane
//   m_tready              per-lane ready
//   drop_count            saturating count of discarded packets
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_OUTPUTS = 3,
    parameter int SEL_WIDTH = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SEL_WIDTH-1:0]       sel,
    input  logic [WIDTH-1:0]           s_tdata,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic [N_OUTPUTS*WIDTH-1:0] m_tdata,
    output logic [N_OUTPUTS-1:0]       m_tvalid,
    output logic [N_OUTPUTS-1:0]       m_tlast,
    input  logic [N_OUTPUTS-1:0]       m_tready,
    output logic [CNT_WIDTH-1:0]       drop_count
);

    localparam int                 CH_W  = clog2(N_OUTPUTS);
    localparam logic [SEL_WIDTH:0] N_OUT = (SEL_WIDTH + 1)'(N_OUTPUTS);

    state_e                 st_r;
    state_e                 st_nxt_s;
    logic [SEL_WIDTH-1:0]   sel_q_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic                   sel_ok_s;
    logic [SEL_WIDTH-1:0]   lane_s;
    logic                   drop_beat_s;
    logic                   accept_s;
    logic                   cnt_inc_s;
    logic                   lane_ready_s;
    logic                   slice_in_ready_s;
    logic                   slice_full_s;
    logic                   slice_drain_s;
    logic [WIDTH-1:0]       slice_data_s;
    logic                   slice_last_s;
    logic [CH_W-1:0]        slice_ch_s;

    assign sel_ok_s = ({1'b0, sel} < N_OUT);

    // Effective lane and whether the current beat is being discarded.
    always_comb begin
        lane_s      = sel;
        drop_beat_s = 1'b0;
        case (st_r)
            S_IDLE: begin
                lane_s      = sel;
                drop_beat_s = !sel_ok_s;
            end
            S_ROUTE: begin
                lane_s      = sel_q_r;
                drop_beat_s = 1'b0;
            end
            S_DROP: begin
                lane_s      = sel_q_r;
                drop_beat_s = 1'b1;
            end
            default: begin
                lane_s      = sel_q_r;
                drop_beat_s = 1'b1;
            end
        endcase
    end

    // Discarded beats are always accepted; routed beats wait for the slice.
    assign s_tready = drop_beat_s ? 1'b1 : slice_in_ready_s;
    assign accept_s = s_tvalid && s_tready;

    // Ready of the lane the held beat is tagged for.
    always_comb begin
        lane_ready_s = 1'b0;
        for (int k = 0; k < N_OUTPUTS; k++) begin
            if (slice_ch_s == CH_W'(k)) begin
                lane_ready_s = m_tready[k];
            end else begin
                lane_ready_s = lane_ready_s;
            end
        end
    end

    stream_demux_slice #(
        .WIDTH    (WIDTH),
        .CH_WIDTH (CH_W)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_tvalid && !drop_beat_s),
        .in_ready  (slice_in_ready_s),
        .in_data   (s_tdata),
        .in_last   (s_tlast),
        .in_ch     (CH_W'(lane_s)),
        .out_ready (lane_ready_s),
        .full      (slice_full_s),
        .drain     (slice_drain_s),
        .data      (slice_data_s),
        .last      (slice_last_s),
        .ch        (slice_ch_s)
    );

    // Packet FSM next state; only accepted beats move it.
    always_comb begin
        st_nxt_s  = st_r;
        cnt_inc_s = 1'b0;
        if (accept_s) begin
            case (st_r)
                S_IDLE: begin
                    if (sel_ok_s) begin
                        st_nxt_s = s_tlast ? S_IDLE : S_ROUTE;
                    end else begin
                        cnt_inc_s = 1'b1;
                        st_nxt_s  = s_tlast ? S_IDLE : S_DROP;
                    end
                end
                S_ROUTE: st_nxt_s = s_tlast ? S_IDLE : S_ROUTE;
                S_DROP:  st_nxt_s = s_tlast ? S_IDLE : S_DROP;
                default: st_nxt_s = S_IDLE;
            endcase
        end else begin
            st_nxt_s = st_r;
        end
    end

    // Packet state, latched lane and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_r    <= S_IDLE;
            sel_q_r <= {SEL_WIDTH{1'b0}};
            cnt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            st_r <= st_nxt_s;
            if (accept_s && (st_r == S_IDLE) && sel_ok_s && !s_tlast) begin
                sel_q_r <= sel;
            end
            if (cnt_inc_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_OUTPUTS; g++) begin : g_lane
            assign m_tvalid[g] = slice_full_s && (slice_ch_s == CH_W'(g));
        end
    endgenerate

    assign m_tdata    = {N_OUTPUTS{slice_data_s}};
    assign m_tlast    = {N_OUTPUTS{slice_last_s}};
    assign drop_count = cnt_r;

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

    logic        clk;
    logic        rst;
    logic [1:0]  sel;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [23:0] m_tdata;
    logic [2:0]  m_tvalid;
    logic [2:0]  m_tlast;
    logic [2:0]  m_tready;
    logic [31:0] drop_count;

    logic        s_tready2;
    logic [23:0] m_tdata2;
    logic [2:0]  m_tvalid2;
    logic [2:0]  m_tlast2;
    logic [1:0]  drop_count2;

    int chk;
    int fail;
    bit rand_ready;

    stream_demux dut (
        .clk(clk), .rst(rst), .sel(sel), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready), .drop_count(drop_count)
    );

    stream_demux #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .sel(sel), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready2), .m_tdata(m_tdata2), .m_tvalid(m_tvalid2),
        .m_tlast(m_tlast2), .m_tready(m_tready), .drop_count(drop_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: per-lane expected beat queues ----------------
    logic [8:0] expq [3][$];
    int         exp_drop;
    int         exp_sat;
    bit         in_pkt;
    int         cur_dest;
    logic [2:0] prev_valid;
    logic [2:0] prev_ready;
    logic [7:0] prev_data;
    logic       prev_last;
    bit         prev_rst;

    initial begin
        in_pkt   = 0;
        exp_drop = 0;
        exp_sat  = 0;
        prev_rst = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < 3; k++) expq[k].delete();
                in_pkt   = 0;
                exp_drop = 0;
                exp_sat  = 0;
                prev_rst = 1;
            end else begin
                check("drop_count", 64'(drop_count), 64'(exp_drop));
                check("drop_count_sat", 64'(drop_count2), 64'(exp_sat));
                check("m_tvalid_onehot0", 64'($onehot0(m_tvalid)), 64'd1);
                if (!prev_rst) begin
                    for (int k = 0; k < 3; k++) begin
                        if (prev_valid[k] && !prev_ready[k]) begin
                            check($sformatf("hold_valid_l%0d", k), 64'(m_tvalid[k]), 64'd1);
                            check($sformatf("hold_data_l%0d", k), 64'(m_tdata[k*8 +: 8]), 64'(prev_data));
                            check($sformatf("hold_last_l%0d", k), 64'(m_tlast[k]), 64'(prev_last));
                        end
                    end
                end
                for (int k = 0; k < 3; k++) begin
                    if (m_tvalid[k] && m_tready[k]) begin
                        if (expq[k].size() == 0) begin
                            check($sformatf("unexpected_beat_l%0d", k), 64'(m_tdata[k*8 +: 8]), 64'h1ff);
                        end else begin
                            logic [8:0] e;
                            e = expq[k].pop_front();
                            check($sformatf("beat_data_l%0d", k), 64'(m_tdata[k*8 +: 8]), 64'(e[7:0]));
                            check($sformatf("beat_last_l%0d", k), 64'(m_tlast[k]), 64'(e[8]));
                        end
                    end
                end
                if (s_tvalid && s_tready) begin
                    if (!in_pkt) begin
                        cur_dest = int'(sel);
                        if (cur_dest >= 3) begin
                            exp_drop = exp_drop + 1;
                            exp_sat  = (exp_sat < 3) ? exp_sat + 1 : 3;
                        end
                    end
                    if (cur_dest < 3) expq[cur_dest].push_back({s_tlast, s_tdata});
                    in_pkt = !s_tlast;
                end
                prev_valid = m_tvalid;
                prev_ready = m_tready;
                prev_data  = m_tdata[7:0];
                prev_last  = m_tlast[0];
                prev_rst   = 0;
            end
        end
    end

    // ---------------- driver helpers (start and end at posedge+1) ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_ready) m_tready = 3'($urandom_range(0, 7));
    endtask

    task automatic put_beat(input logic [1:0] s, input logic [7:0] d, input logic l);
        bit acc;
        acc      = 0;
        s_tvalid = 1'b1;
        sel      = s;
        s_tdata  = d;
        s_tlast  = l;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = s_tready;
            cyc();
        end
        if (!acc) check("beat_accept_timeout", 64'd0, 64'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic send_packet(input int dest, input int len, input logic [7:0] base, input bit toggle);
        for (int i = 0; i < len; i++) begin
            logic [1:0] s;
            if (i == 0) s = 2'(dest);
            else if (toggle) s = 2'd0;
            else s = 2'($urandom_range(0, 3));
            put_beat(s, base + 8'(i), (i == len - 1));
            if (rand_ready) repeat ($urandom_range(0, 2)) cyc();
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       vld;
        logic [7:0] data;
        logic       last;
        logic [2:0] rdy;
        logic       exp_rdy;
        logic [2:0] exp_mv;
        logic [7:0] exp_d;
        logic       exp_l;
    } vec_t;

    vec_t tbl[5];

    initial begin
        chk        = 0;
        fail       = 0;
        rand_ready = 0;
        rst        = 1'b1;
        sel        = 2'd0;
        s_tdata    = 8'hff;
        s_tvalid   = 1'b1;
        s_tlast    = 1'b0;
        m_tready   = 3'b111;

        // Reset with valid input asserted: outputs zero, input not taken.
        repeat (5) begin
            @(negedge clk);
            check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
            check("rst_m_tdata", 64'(m_tdata), 64'd0);
            check("rst_m_tlast", 64'(m_tlast), 64'd0);
            check("rst_drop_count", 64'(drop_count), 64'd0);
            check("rst_s_tready", 64'(s_tready), 64'd1);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        s_tvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
            cyc();
        end

        // Single-beat routing, back to back, each lane in turn.
        tbl[0] = '{2'd0, 1'b1, 8'h55, 1'b1, 3'b111, 1'b1, 3'b000, 8'h00, 1'b0};
        tbl[1] = '{2'd1, 1'b1, 8'h55, 1'b1, 3'b111, 1'b1, 3'b001, 8'h55, 1'b1};
        tbl[2] = '{2'd2, 1'b1, 8'h55, 1'b1, 3'b111, 1'b1, 3'b010, 8'h55, 1'b1};
        tbl[3] = '{2'd0, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b100, 8'h55, 1'b1};
        tbl[4] = '{2'd0, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 8'h00, 1'b0};
        for (int i = 0; i < 5; i++) begin
            sel      = tbl[i].sel;
            s_tvalid = tbl[i].vld;
            s_tdata  = tbl[i].data;
            s_tlast  = tbl[i].last;
            m_tready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("tbl%0d_s_tready", i), 64'(s_tready), 64'(tbl[i].exp_rdy));
            check($sformatf("tbl%0d_m_tvalid", i), 64'(m_tvalid), 64'(tbl[i].exp_mv));
            if (tbl[i].exp_mv != 3'b000) begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("tbl%0d_m_tdata_l%0d", i, k), 64'(m_tdata[k*8 +: 8]), 64'(tbl[i].exp_d));
                end
                check($sformatf("tbl%0d_m_tlast", i), 64'(m_tlast), {61'd0, {3{tbl[i].exp_l}}});
            end
            cyc();
        end

        // Packet hold: sel moves to 0 after the first beat.
        send_packet(1, 4, 8'h10, 1'b1);
        repeat (3) cyc();

        // Backpressure on lane 2 for six cycles mid-packet.
        m_tready = 3'b111;
        put_beat(2'd2, 8'h20, 1'b0);
        m_tready = 3'b011;
        s_tvalid = 1'b1;
        sel      = 2'd0;
        s_tdata  = 8'h21;
        s_tlast  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("bp_s_tready", 64'(s_tready), 64'd0);
            check("bp_m_tvalid", 64'(m_tvalid), 64'b100);
            check("bp_m_tdata", 64'(m_tdata[23:16]), 64'h20);
            cyc();
        end
        m_tready = 3'b111;
        put_beat(2'd0, 8'h21, 1'b0);
        put_beat(2'd1, 8'h22, 1'b1);
        repeat (3) cyc();

        // Drop: 3-beat packet to lane 3 is swallowed and counted once.
        @(negedge clk);
        check("drop_before", 64'(drop_count), 64'd0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            sel      = 2'd3;
            s_tdata  = 8'h30 + 8'(i);
            s_tlast  = (i == 2);
            @(negedge clk);
            check("drop_s_tready", 64'(s_tready), 64'd1);
            check("drop_m_tvalid", 64'(m_tvalid), 64'd0);
            cyc();
        end
        s_tvalid = 1'b0;
        @(negedge clk);
        check("drop_after", 64'(drop_count), 64'd1);
        cyc();
        for (int i = 0; i < 4; i++) put_beat(2'd3, 8'h38 + 8'(i), 1'b1);
        cyc();
        @(negedge clk);
        check("sat_count", 64'(drop_count2), 64'd3);
        check("wide_count", 64'(drop_count), 64'd5);
        cyc();

        // Reset mid-packet, then a new packet to lane 2.
        put_beat(2'd0, 8'h40, 1'b0);
        put_beat(2'd0, 8'h41, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        cyc();
        s_tvalid = 1'b1;
        sel      = 2'd2;
        s_tdata  = 8'h50;
        s_tlast  = 1'b0;
        @(negedge clk);
        check("midrst_first_ready", 64'(s_tready), 64'd1);
        cyc();
        s_tvalid = 1'b0;
        @(negedge clk);
        check("midrst_lane", 64'(m_tvalid), 64'b100);
        cyc();
        put_beat(2'd0, 8'h51, 1'b1);
        repeat (3) cyc();

        // Randomized traffic with random per-lane ready.
        rand_ready = 1;
        for (int p = 0; p < 40; p++) begin
            send_packet($urandom_range(0, 3), $urandom_range(1, 5), 8'($urandom), 1'b0);
        end
        rand_ready = 0;
        m_tready   = 3'b111;
        for (int t = 0; t < 100; t++) begin
            if (expq[0].size() == 0 && expq[1].size() == 0 && expq[2].size() == 0) break;
            cyc();
        end
        cyc();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drain_empty_l%0d", k), 64'(expq[k].size()), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", chk, fail);
        $finish;
    end

endmodule
